// File: rtl/esp8266_frame_scheduler_pkg.sv
// rtl/esp8266_frame_scheduler_pkg.sv - shared state encoding and frame constants for the frame scheduler
package esp8266_frame_scheduler_pkg;

  localparam int SLOT_W = 32;
  localparam int BYTES_PER_FRAME = 34;
  localparam logic [7:0] FRAME_HEADER = 8'hA5;
  localparam logic [7:0] FRAME_ADDR = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_START,
    ST_SEND,
    ST_GAP
  } state_t;

endpackage

// File: rtl/esp8266_frame_scheduler_ack.sv
// rtl/esp8266_frame_scheduler_ack.sv - rising-edge counter with clear and terminal-count flag
module rise_edge_counter #(
  parameter int TERMINAL = 34
) (
  input  logic clock,
  input  logic reset_n,
  input  logic level,
  input  logic clear,
  input  logic count_en,
  output logic terminal
);

  localparam int WIDTH = $clog2(TERMINAL + 1);

  logic             level_q;
  logic             rise;
  logic [WIDTH-1:0] count;

  assign rise     = level & ~level_q;
  assign terminal = count_en && rise && (count == WIDTH'(TERMINAL - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= 1'b0;
      count   <= '0;
    end else begin
      level_q <= level;
      if (clear)
        count <= '0;
      else if (count_en && rise)
        count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/esp8266_frame_scheduler.sv
// rtl/esp8266_frame_scheduler.sv - snapshots sensor shadows into frames and paces them to the SPI feeder
module esp8266_frame_scheduler #(
  parameter int NUM_SENSORS     = 8,
  parameter int BYTES_PER_FRAME = esp8266_frame_scheduler_pkg::BYTES_PER_FRAME,
  parameter int MIN_GAP_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES  = 50000
) (
  input  logic                                                     clock,
  input  logic                                                     reset_n,
  input  logic                                                     enable,
  input  logic [esp8266_frame_scheduler_pkg::SLOT_W*NUM_SENSORS-1:0] sensor_data,
  input  logic [NUM_SENSORS-1:0]                                   sensor_valid,
  input  logic                                                     write_ack,
  output logic [esp8266_frame_scheduler_pkg::SLOT_W*NUM_SENSORS-1:0] frame_data,
  output logic                                                     data_ready,
  output logic                                                     busy,
  output logic [31:0]                                              frames_sent,
  output logic [15:0]                                              overruns,
  output logic [15:0]                                              timeouts
);

  import esp8266_frame_scheduler_pkg::*;

  localparam int TIMER_MAX = (TIMEOUT_CYCLES > MIN_GAP_CYCLES) ? TIMEOUT_CYCLES : MIN_GAP_CYCLES + 1;
  localparam int TW = $clog2(TIMER_MAX + 1);
  localparam int HW = $clog2(NUM_SENSORS + 1);

  state_t                             state, state_next;
  logic [NUM_SENSORS-1:0][SLOT_W-1:0] shadow;
  logic [NUM_SENSORS-1:0]             pending, live_pending;
  logic [TW-1:0]                      timer;
  logic [HW-1:0]                      overrun_hits;
  logic [16:0]                        overrun_sum;
  logic                               ack_done, timed_out;

  rise_edge_counter #(.TERMINAL(BYTES_PER_FRAME)) u_ack (
    .clock    (clock),
    .reset_n  (reset_n),
    .level    (write_ack),
    .clear    (state == ST_START),
    .count_en (state == ST_SEND),
    .terminal (ack_done)
  );

  // Timer is cleared in START, so it reaches TIMEOUT-2 exactly TIMEOUT clocks after START is entered.
  assign timed_out = (state == ST_SEND) && !ack_done && (timer == TW'(TIMEOUT_CYCLES - 2));

  // Slots being latched this cycle are not overruns: their old value goes out in this frame.
  assign live_pending = (state == ST_LATCH) ? '0 : pending;

  always_comb begin
    overrun_hits = '0;
    for (int i = 0; i < NUM_SENSORS; i++)
      overrun_hits = overrun_hits + HW'(sensor_valid[i] & live_pending[i]);
    overrun_sum = {1'b0, overruns} + 17'(overrun_hits);
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (enable && |pending) state_next = ST_LATCH;
      ST_LATCH: state_next = ST_START;
      ST_START: state_next = ST_SEND;
      ST_SEND:  if (ack_done || timed_out) state_next = ST_GAP;
      ST_GAP:   if (timer == TW'(MIN_GAP_CYCLES)) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      data_ready <= 1'b0;
    end else begin
      state      <= state_next;
      busy       <= (state_next == ST_LATCH) || (state_next == ST_START) || (state_next == ST_SEND);
      data_ready <= (state_next == ST_START);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow      <= '0;
      pending     <= '0;
      frame_data  <= '0;
      timer       <= '0;
      frames_sent <= '0;
      overruns    <= '0;
      timeouts    <= '0;
    end else begin
      for (int i = 0; i < NUM_SENSORS; i++)
        if (sensor_valid[i]) shadow[i] <= sensor_data[i*SLOT_W +: SLOT_W];
      pending  <= live_pending | sensor_valid;
      overruns <= overrun_sum[16] ? 16'hFFFF : overrun_sum[15:0];
      if (state == ST_LATCH)
        frame_data <= shadow;
      if (state == ST_START || (state == ST_SEND && state_next == ST_GAP))
        timer <= '0;
      else if (state == ST_SEND || state == ST_GAP)
        timer <= timer + 1'b1;
      if (ack_done)
        frames_sent <= frames_sent + 1'b1;
      if (timed_out && timeouts != 16'hFFFF)
        timeouts <= timeouts + 1'b1;
    end
  end

endmodule

// File: tb/tb_esp8266_frame_scheduler.sv
// tb/tb_esp8266_frame_scheduler.sv - scoreboard bench with a slot-level reference model
`timescale 1ns/1ps
module tb_esp8266_frame_scheduler;

  localparam int NS  = 8;
  localparam int BPF = 34;
  localparam int GAP = 20;
  localparam int TMO = 200;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b0;
  logic         write_ack = 1'b0;
  logic [255:0] sensor_data = '0;
  logic [7:0]   sensor_valid = '0;
  logic [255:0] frame_data;
  logic         data_ready, busy;
  logic [31:0]  frames_sent;
  logic [15:0]  overruns, timeouts;

  esp8266_frame_scheduler #(
    .NUM_SENSORS(NS), .BYTES_PER_FRAME(BPF), .MIN_GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .sensor_data(sensor_data),
    .sensor_valid(sensor_valid), .write_ack(write_ack), .frame_data(frame_data),
    .data_ready(data_ready), .busy(busy), .frames_sent(frames_sent),
    .overruns(overruns), .timeouts(timeouts)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0]  m_shadow [NS];
  logic [NS-1:0] m_pend;
  int           m_frames, m_over, m_to;
  logic [255:0] exp_q [$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every data_ready pulse must carry the next frame the model predicted.
  logic dr_prev = 1'b0;
  always @(negedge clock) begin
    if (data_ready) begin
      check("data_ready_one_cycle", dr_prev, 1'b0);
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_frame: got %0h expected no frame (cycle %0d)", frame_data, cyc);
      end else begin
        check("frame_data", frame_data, exp_q.pop_front());
      end
    end
    dr_prev = data_ready;
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_shadow[i] = '0;
    m_pend = '0; m_frames = 0; m_over = 0; m_to = 0;
    exp_q.delete();
  endtask

  task automatic model_latch();
    logic [255:0] snap;
    for (int i = 0; i < NS; i++) snap[i*32 +: 32] = m_shadow[i];
    exp_q.push_back(snap);
    m_pend = '0;
  endtask

  function automatic logic [255:0] rnd_data();
    logic [255:0] d;
    for (int i = 0; i < NS; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic apply_strobe(input logic [7:0] mask, input logic [255:0] data);
    sensor_valid = mask;
    sensor_data  = data;
    for (int i = 0; i < NS; i++) begin
      if (mask[i]) begin
        if (m_pend[i]) m_over = (m_over < 65535) ? m_over + 1 : 65535;
        m_shadow[i] = data[i*32 +: 32];
        m_pend[i]   = 1'b1;
      end
    end
    tick();
    sensor_valid = '0;
    sensor_data  = rnd_data();
  endtask

  task automatic send_acks(input int n, input bit last_done, output int g);
    g = 0;
    for (int k = 0; k < n; k++) begin
      write_ack = 1'b1;
      tick();
      if (k == n - 1) begin
        g = cyc;
        if (last_done) begin
          m_frames++;
          check("busy_falls_on_last_ack", busy, 1'b0);
          check("frames_sent", frames_sent, m_frames);
        end else begin
          check("busy_held", busy, 1'b1);
        end
      end
      repeat ($urandom_range(0, 1)) tick();
      write_ack = 1'b0;
      repeat ($urandom_range(1, 2)) tick();
    end
  endtask

  task automatic wait_dr(output int c);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!data_ready && n < 1000);
    if (!data_ready) begin
      n_checks++; n_fail++;
      $display("FAIL wait_data_ready: got no pulse expected one within 1000 cycles");
    end
    c = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, g2, c, c_s, n, ns;
    bit seen;
    logic [255:0] d;
    logic [7:0] mask;

    model_reset();
    repeat (3) tick();
    check("reset_frame_data", frame_data, '0);
    check("reset_data_ready", data_ready, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_frames_sent", frames_sent, '0);
    check("reset_overruns", overruns, '0);
    check("reset_timeouts", timeouts, '0);
    reset_n = 1'b1;
    tick();

    // slot 0 capture and two-clock start latency
    enable = 1'b1;
    d = rnd_data(); d[31:0] = 32'hDEADBEEF;
    apply_strobe(8'h01, d);
    model_latch();
    tick();
    check("dr_latency_early", data_ready, 1'b0);
    tick();
    check("dr_latency", data_ready, 1'b1);
    check("busy_in_start", busy, 1'b1);
    tick();
    send_acks(BPF, 1'b1, g);

    // double strobe in gap, then a strobe in the LATCH cycle
    d = rnd_data(); apply_strobe(8'h08, d);
    d = rnd_data(); apply_strobe(8'h08, d);
    check("overrun_double_strobe", overruns, m_over);
    model_latch();
    seen = 1'b0;
    while (cyc < g + GAP + 2) begin
      tick();
      if (data_ready) seen = 1'b1;
    end
    check("no_dr_during_gap", seen, 1'b0);
    d = rnd_data(); apply_strobe(8'h08, d);
    model_latch();
    check("dr_after_gap", data_ready, 1'b1);
    check("gap_cycle", cyc, g + GAP + 3);
    check("overrun_latch_strobe", overruns, m_over);
    tick();
    send_acks(BPF, 1'b1, g2);
    wait_dr(c);
    check("second_frame_cycle", c, g2 + GAP + 3);

    // timeout after only 20 acks
    c_s = c;
    tick();
    send_acks(20, 1'b0, g);
    n = 0;
    while (timeouts == 16'(m_to) && n < 2 * TMO) begin
      tick();
      n++;
    end
    m_to++;
    check("timeouts", timeouts, m_to);
    check("timeout_cycle", cyc, c_s + TMO);
    check("timeout_frames_sent", frames_sent, m_frames);
    check("timeout_busy", busy, 1'b0);
    g = cyc;
    d = rnd_data(); apply_strobe(8'h02, d);
    model_latch();
    wait_dr(c);
    check("idle_after_timeout_gap", c, g + GAP + 3);

    // ack held high across START is not counted
    write_ack = 1'b1;
    tick(); tick();
    write_ack = 1'b0;
    tick();
    send_acks(BPF - 1, 1'b0, g);
    check("held_ack_frames_sent", frames_sent, m_frames);
    send_acks(1, 1'b1, g);

    // enable dropped mid-SEND: frame completes, nothing new starts
    repeat (GAP + 3) tick();
    d = rnd_data(); apply_strobe(8'h20, d);
    model_latch();
    wait_dr(c);
    tick();
    enable = 1'b0;
    d = rnd_data(); apply_strobe(8'h40, d);
    send_acks(BPF, 1'b1, g);
    seen = 1'b0;
    repeat (GAP + 20) begin
      tick();
      if (data_ready) seen = 1'b1;
    end
    check("no_start_when_disabled", seen, 1'b0);

    // reset pulse mid-SEND
    enable = 1'b1;
    model_latch();
    wait_dr(c);
    tick();
    send_acks(10, 1'b0, g);
    reset_n = 1'b0;
    write_ack = 1'b0;
    #1;
    check("midreset_frame_data", frame_data, '0);
    check("midreset_data_ready", data_ready, 1'b0);
    check("midreset_busy", busy, 1'b0);
    check("midreset_frames_sent", frames_sent, '0);
    check("midreset_overruns", overruns, '0);
    check("midreset_timeouts", timeouts, '0);
    model_reset();
    tick(); tick();
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (data_ready) seen = 1'b1;
    end
    check("no_frame_after_reset", seen, 1'b0);

    // randomized rounds
    for (int r = 0; r < 4; r++) begin
      enable = 1'b0;
      ns = $urandom_range(3, 8);
      for (int s = 0; s < ns; s++) begin
        mask = 8'($urandom);
        if (s == 0) mask[r] = 1'b1;
        apply_strobe(mask, rnd_data());
      end
      check("overruns_random", overruns, m_over);
      enable = 1'b1;
      model_latch();
      tick();
      check("rand_dr_early", data_ready, 1'b0);
      tick();
      check("rand_dr", data_ready, 1'b1);
      tick();
      send_acks(BPF, 1'b1, g);
      enable = 1'b0;
      repeat (GAP + 3) tick();
    end

    check("frames_final", frames_sent, m_frames);
    check("timeouts_final", timeouts, m_to);
    check("scoreboard_drained", 256'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
